// File: rtl/src_pkg.sv
// ----------------------------------------------------------------------------
// src_pkg
// Shared definitions for the parametrised Mini SRC datapath:
//   - bus-select offsets for the non-GPR sources (added to NUM_GPR)
//   - memory-interface FSM state encoding
//   - selWidth(): width of the encoded bus selector for a given GPR count
// ----------------------------------------------------------------------------
package src_pkg;

    localparam int SEL_PC      = 0;
    localparam int SEL_HI      = 1;
    localparam int SEL_LO      = 2;
    localparam int SEL_ZHI     = 3;
    localparam int SEL_ZLO     = 4;
    localparam int SEL_MDR     = 5;
    localparam int NUM_SPECIAL = 6;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_RD_WAIT = 2'd1,
        MEM_WR_WAIT = 2'd2
    } memState_e;

    function automatic int selWidth(input int numGpr);
        return $clog2(numGpr + NUM_SPECIAL);
    endfunction

endpackage

// File: rtl/reg_w.sv
// ----------------------------------------------------------------------------
// reg_w
// Width-parametrised load-enable register used for every datapath register.
// Ports:
//   clock_i    rising-edge clock
//   clear_n_i  asynchronous active-low reset (loads RESET_VAL)
//   we_i       load enable
//   d_i        data in
//   q_o        registered value
// ----------------------------------------------------------------------------
module reg_w #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clock_i,
    input  logic         clear_n_i,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] value_q;

    // Holds its value unless enabled; reset forces RESET_VAL immediately.
    always_ff @(posedge clock_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            value_q <= RESET_VAL;
        end else if (we_i) begin
            value_q <= d_i;
        end
    end

    assign q_o = value_q;

endmodule

// File: rtl/src_mem_if.sv
// ----------------------------------------------------------------------------
// src_mem_if
// Memory handshake FSM with timeout for the Mini SRC datapath.
// Ports:
//   clock_i, clear_n_i       clock / asynchronous active-low reset
//   memRd_i, memWr_i         start a read (wins) or write from IDLE
//   memAck_i                 memory completion
//   mdrWe_i, marWe_i         control-unit enables for MDR/MAR
//   mdrWeOk_o, marWeOk_o     those enables, blocked while a transfer is open
//   mdrFromMem_o             load MDR from memory read data this cycle
//   memReq_o, memWe_o        request / write flag, held while waiting
//   memBusy_o                FSM not idle
//   memDone_o, memErr_o      registered one-cycle completion / timeout pulses
// ----------------------------------------------------------------------------
module src_mem_if
    import src_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clock_i,
    input  logic clear_n_i,
    input  logic memRd_i,
    input  logic memWr_i,
    input  logic memAck_i,
    input  logic mdrWe_i,
    input  logic marWe_i,
    output logic mdrWeOk_o,
    output logic marWeOk_o,
    output logic mdrFromMem_o,
    output logic memReq_o,
    output logic memWe_o,
    output logic memBusy_o,
    output logic memDone_o,
    output logic memErr_o
);

    memState_e   state_q, state_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // State, wait counter and completion pulses; reset drops the request at once.
    always_ff @(posedge clock_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            state_q   <= MEM_IDLE;
            waitCnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Ack beats timeout when both land in the same cycle.
    always_comb begin
        state_d      = state_q;
        waitCnt_d    = waitCnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        mdrFromMem_o = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                waitCnt_d = '0;
                if (memRd_i) begin
                    state_d = MEM_RD_WAIT;
                end else if (memWr_i) begin
                    state_d = MEM_WR_WAIT;
                end
            end
            MEM_RD_WAIT, MEM_WR_WAIT: begin
                if (memAck_i) begin
                    mdrFromMem_o = (state_q == MEM_RD_WAIT);
                    done_d       = 1'b1;
                    state_d      = MEM_IDLE;
                end else if (waitCnt_q == 8'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = MEM_IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    assign memBusy_o = (state_q != MEM_IDLE);
    assign memReq_o  = memBusy_o;
    assign memWe_o   = (state_q == MEM_WR_WAIT);
    assign mdrWeOk_o = mdrWe_i && !memBusy_o;
    assign marWeOk_o = marWe_i && !memBusy_o;
    assign memDone_o = done_q;
    assign memErr_o  = err_q;

endmodule

// File: rtl/src_datapath_param.sv
// ----------------------------------------------------------------------------
// src_datapath_param
// Parametrised Mini SRC datapath: GPR file, PC, IR, Y, Z (2*WIDTH), HI, LO,
// MAR, MDR around one shared bus, plus the memory handshake interface.
// Ports:
//   clock_i, clear_n_i     clock / asynchronous active-low reset
//   gprWe_i                one-hot GPR load from bus
//   pcWe_i .. mdrWe_i      per-register load from bus
//   zWe_i                  load Z from aluResult_i
//   incPc_i                PC <= PC + PC_STEP (pcWe_i has priority)
//   r0Base_i               r0 reads as zero on the bus (when R0_ZERO)
//   busSel_i               encoded bus source
//   memRd_i, memWr_i, memRdata_i, memAck_i   memory side inputs
//   busData_o, yOut_o, irOut_o               datapath outputs
//   memReq_o, memWe_o, memAddr_o, memWdata_o, memBusy_o, memDone_o, memErr_o
// ----------------------------------------------------------------------------
module src_datapath_param
    import src_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               NUM_GPR  = 16,
    parameter bit               R0_ZERO  = 1'b1,
    parameter int               PC_STEP  = 1,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               TIMEOUT  = 255,
    parameter int               SEL_W    = selWidth(NUM_GPR)
) (
    input  logic                 clock_i,
    input  logic                 clear_n_i,
    input  logic [NUM_GPR-1:0]   gprWe_i,
    input  logic                 pcWe_i,
    input  logic                 irWe_i,
    input  logic                 yWe_i,
    input  logic                 hiWe_i,
    input  logic                 loWe_i,
    input  logic                 marWe_i,
    input  logic                 mdrWe_i,
    input  logic                 zWe_i,
    input  logic                 incPc_i,
    input  logic                 r0Base_i,
    input  logic [SEL_W-1:0]     busSel_i,
    input  logic [2*WIDTH-1:0]   aluResult_i,
    input  logic                 memRd_i,
    input  logic                 memWr_i,
    input  logic [WIDTH-1:0]     memRdata_i,
    input  logic                 memAck_i,
    output logic [WIDTH-1:0]     busData_o,
    output logic [WIDTH-1:0]     yOut_o,
    output logic [WIDTH-1:0]     irOut_o,
    output logic                 memReq_o,
    output logic                 memWe_o,
    output logic [WIDTH-1:0]     memAddr_o,
    output logic [WIDTH-1:0]     memWdata_o,
    output logic                 memBusy_o,
    output logic                 memDone_o,
    output logic                 memErr_o
);

    localparam int GPR_IDX_W = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

    logic [WIDTH-1:0]   busData;
    logic [WIDTH-1:0]   gpr_q [NUM_GPR];
    logic [WIDTH-1:0]   pc_q, pc_d, ir_q, y_q, hi_q, lo_q, mar_q, mdr_q, mdr_d;
    logic [2*WIDTH-1:0] z_q;
    logic               mdrWeOk, marWeOk, mdrFromMem;

    // Shared bus: GPRs occupy the low codes, special registers follow.
    always_comb begin
        busData = '0;
        if (int'(busSel_i) < NUM_GPR) begin
            if (!(busSel_i == '0 && R0_ZERO && r0Base_i)) begin
                busData = gpr_q[busSel_i[GPR_IDX_W-1:0]];
            end
        end else begin
            case (int'(busSel_i) - NUM_GPR)
                SEL_PC:  busData = pc_q;
                SEL_HI:  busData = hi_q;
                SEL_LO:  busData = lo_q;
                SEL_ZHI: busData = z_q[2*WIDTH-1:WIDTH];
                SEL_ZLO: busData = z_q[WIDTH-1:0];
                SEL_MDR: busData = mdr_q;
                default: busData = '0;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_GPR; g++) begin : gGpr
        reg_w #(.W(WIDTH)) uGpr (
            .clock_i(clock_i), .clear_n_i(clear_n_i), .we_i(gprWe_i[g]),
            .d_i(busData), .q_o(gpr_q[g])
        );
    end

    assign pc_d = pcWe_i ? busData : pc_q + WIDTH'(PC_STEP);

    reg_w #(.W(WIDTH), .RESET_VAL(RESET_PC)) uPc (
        .clock_i(clock_i), .clear_n_i(clear_n_i), .we_i(pcWe_i | incPc_i),
        .d_i(pc_d), .q_o(pc_q)
    );
    reg_w #(.W(WIDTH)) uIr (
        .clock_i(clock_i), .clear_n_i(clear_n_i), .we_i(irWe_i), .d_i(busData), .q_o(ir_q)
    );
    reg_w #(.W(WIDTH)) uY (
        .clock_i(clock_i), .clear_n_i(clear_n_i), .we_i(yWe_i), .d_i(busData), .q_o(y_q)
    );
    reg_w #(.W(WIDTH)) uHi (
        .clock_i(clock_i), .clear_n_i(clear_n_i), .we_i(hiWe_i), .d_i(busData), .q_o(hi_q)
    );
    reg_w #(.W(WIDTH)) uLo (
        .clock_i(clock_i), .clear_n_i(clear_n_i), .we_i(loWe_i), .d_i(busData), .q_o(lo_q)
    );
    reg_w #(.W(2*WIDTH)) uZ (
        .clock_i(clock_i), .clear_n_i(clear_n_i), .we_i(zWe_i), .d_i(aluResult_i), .q_o(z_q)
    );
    reg_w #(.W(WIDTH)) uMar (
        .clock_i(clock_i), .clear_n_i(clear_n_i), .we_i(marWeOk), .d_i(busData), .q_o(mar_q)
    );

    // MDR takes memory data on a read ack; the bus path is blocked while busy,
    // so the two sources never collide.
    assign mdr_d = mdrFromMem ? memRdata_i : busData;

    reg_w #(.W(WIDTH)) uMdr (
        .clock_i(clock_i), .clear_n_i(clear_n_i), .we_i(mdrWeOk | mdrFromMem),
        .d_i(mdr_d), .q_o(mdr_q)
    );

    src_mem_if #(.TIMEOUT(TIMEOUT)) uMemIf (
        .clock_i(clock_i), .clear_n_i(clear_n_i),
        .memRd_i(memRd_i), .memWr_i(memWr_i), .memAck_i(memAck_i),
        .mdrWe_i(mdrWe_i), .marWe_i(marWe_i),
        .mdrWeOk_o(mdrWeOk), .marWeOk_o(marWeOk), .mdrFromMem_o(mdrFromMem),
        .memReq_o(memReq_o), .memWe_o(memWe_o), .memBusy_o(memBusy_o),
        .memDone_o(memDone_o), .memErr_o(memErr_o)
    );

    assign busData_o  = busData;
    assign yOut_o     = y_q;
    assign irOut_o    = ir_q;
    assign memAddr_o  = mar_q;
    assign memWdata_o = mdr_q;

endmodule

// File: tb/tb_src_datapath_param.sv
// ----------------------------------------------------------------------------
// tb_src_datapath_param
// Scoreboard bench: stimulus pushes expected observations into queues, a
// monitor on the falling edge pops and compares them.
// ----------------------------------------------------------------------------
module tb_src_datapath_param;

    localparam int          TOUT = 12;
    localparam logic [31:0] RPC  = 32'h0000_0100;

    localparam logic [4:0] S_PC = 5'd16, S_HI = 5'd17, S_LO = 5'd18;
    localparam logic [4:0] S_ZHI = 5'd19, S_ZLO = 5'd20, S_MDR = 5'd21, S_BAD = 5'd26;

    localparam logic [9:0] C_PC  = 10'b10_0000_0000, C_IR  = 10'b01_0000_0000;
    localparam logic [9:0] C_Y   = 10'b00_1000_0000, C_HI  = 10'b00_0100_0000;
    localparam logic [9:0] C_LO  = 10'b00_0010_0000, C_MAR = 10'b00_0001_0000;
    localparam logic [9:0] C_MDR = 10'b00_0000_1000, C_INC = 10'b00_0000_0100;
    localparam logic [9:0] C_RD  = 10'b00_0000_0010, C_WR  = 10'b00_0000_0001;

    localparam int O_BUS = 0, O_ADDR = 1, O_IR = 2, O_Y = 3;
    localparam int O_REQ = 4, O_WE = 5, O_BUSY = 6, O_WDATA = 7;

    typedef struct {
        string       name;
        int          src;
        logic [31:0] exp;
    } probe_t;

    typedef struct {
        string name;
        bit    isErr;
    } event_t;

    logic        clock, clear_n;
    logic [15:0] gprWe;
    logic        pcWe, irWe, yWe, hiWe, loWe, marWe, mdrWe, zWe, incPc, r0Base;
    logic [4:0]  busSel;
    logic [63:0] aluResult;
    logic        memRd, memWr, memAck;
    logic [31:0] memRdata;
    logic [31:0] busData, yOut, irOut, memAddr, memWdata;
    logic        memReq, memWe, memBusy, memDone, memErr;

    probe_t probeQ[$];
    event_t evQ[$];
    logic   probe;
    int     passCount = 0;
    int     checkCount = 0;

    src_datapath_param #(
        .WIDTH(32), .NUM_GPR(16), .R0_ZERO(1'b1), .PC_STEP(1),
        .RESET_PC(RPC), .TIMEOUT(TOUT)
    ) dut (
        .clock_i(clock), .clear_n_i(clear_n), .gprWe_i(gprWe),
        .pcWe_i(pcWe), .irWe_i(irWe), .yWe_i(yWe), .hiWe_i(hiWe), .loWe_i(loWe),
        .marWe_i(marWe), .mdrWe_i(mdrWe), .zWe_i(zWe), .incPc_i(incPc),
        .r0Base_i(r0Base), .busSel_i(busSel), .aluResult_i(aluResult),
        .memRd_i(memRd), .memWr_i(memWr), .memRdata_i(memRdata), .memAck_i(memAck),
        .busData_o(busData), .yOut_o(yOut), .irOut_o(irOut),
        .memReq_o(memReq), .memWe_o(memWe), .memAddr_o(memAddr), .memWdata_o(memWdata),
        .memBusy_o(memBusy), .memDone_o(memDone), .memErr_o(memErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Selects which DUT output a queued observation refers to.
    function automatic logic [31:0] pick(input int src);
        case (src)
            O_BUS:   return busData;
            O_ADDR:  return memAddr;
            O_IR:    return irOut;
            O_Y:     return yOut;
            O_REQ:   return {31'b0, memReq};
            O_WE:    return {31'b0, memWe};
            O_BUSY:  return {31'b0, memBusy};
            O_WDATA: return memWdata;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: pops an observation whenever one is presented, and an
    // expected memory event whenever the DUT pulses done or err.
    always @(negedge clock) begin
        probe_t      p;
        event_t      e;
        logic [31:0] act;
        if (probe) begin
            checkCount++;
            if (probeQ.size() == 0) begin
                $display("[TB] FAIL probeUnderflow: observation with no expectation");
            end else begin
                p   = probeQ.pop_front();
                act = pick(p.src);
                if (act === p.exp) passCount++;
                else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", p.name, act, p.exp);
            end
        end
        if (memDone || memErr) begin
            checkCount++;
            if (evQ.size() == 0) begin
                $display("[TB] FAIL unexpectedEvent: done=%0b err=%0b with none expected",
                         memDone, memErr);
            end else begin
                e = evQ.pop_front();
                if ({memDone, memErr} === {!e.isErr, e.isErr}) passCount++;
                else $display("[TB] FAIL %s: got done=%0b err=%0b expected done=%0b err=%0b",
                              e.name, memDone, memErr, !e.isErr, e.isErr);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] sel, input logic [15:0] gpr,
                                 input logic [9:0] ctl);
        busSel = sel;
        gprWe  = gpr;
        {pcWe, irWe, yWe, hiWe, loWe, marWe, mdrWe, incPc, memRd, memWr} = ctl;
    endtask

    task automatic loadZ(input logic [63:0] v);
        aluResult = v;
        zWe       = 1'b1;
        tick();
        zWe       = 1'b0;
    endtask

    task automatic writeReg(input logic [31:0] v, input logic [15:0] gpr,
                            input logic [9:0] ctl);
        loadZ({32'h0, v});
        applyStimulus(S_ZLO, gpr, ctl);
        tick();
        applyStimulus(S_ZLO, 16'h0, 10'h0);
    endtask

    task automatic checkOutput(input string name, input int src, input logic [31:0] exp);
        probeQ.push_back('{name, src, exp});
        probe = 1'b1;
        @(negedge clock);
        #1;
        probe = 1'b0;
    endtask

    task automatic compareNow(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int errAt;
        clear_n = 1'b0; probe = 1'b0; zWe = 1'b0; r0Base = 1'b0;
        aluResult = '0; memRdata = '0; memAck = 1'b0;
        applyStimulus(5'd0, 16'h0, 10'h0);

        // Reset state
        applyStimulus(S_PC, 16'h0, 10'h0);
        checkOutput("rstPc", O_BUS, RPC);
        applyStimulus(5'd0, 16'h0, 10'h0);
        checkOutput("rstBusR0", O_BUS, 32'h0);
        checkOutput("rstReq", O_REQ, 32'h0);
        checkOutput("rstY", O_Y, 32'h0);
        compareNow("rstDoneErr", {30'b0, memDone, memErr}, 32'h0);
        clear_n = 1'b1;
        tick();

        // Bus transfers and r0 base rule
        writeReg(32'hDEAD_BEEF, 16'h0020, 10'h0);
        applyStimulus(5'd5, 16'h0008, 10'h0);
        checkOutput("busR5", O_BUS, 32'hDEAD_BEEF);
        tick();
        applyStimulus(5'd3, 16'h0, 10'h0);
        checkOutput("r3FromR5", O_BUS, 32'hDEAD_BEEF);
        writeReg(32'h7, 16'h0001, 10'h0);
        applyStimulus(5'd0, 16'h0, 10'h0);
        checkOutput("r0Plain", O_BUS, 32'h7);
        r0Base = 1'b1;
        checkOutput("r0Base", O_BUS, 32'h0);
        r0Base = 1'b0;

        // PC increment, load priority and wrap
        applyStimulus(S_BAD, 16'h0, C_PC);
        tick();
        applyStimulus(S_BAD, 16'h0, 10'h0);
        checkOutput("unusedSelA", O_BUS, 32'h0);
        applyStimulus(S_PC, 16'h0, C_INC);
        tick(); tick(); tick();
        applyStimulus(S_PC, 16'h0, 10'h0);
        checkOutput("pcInc3", O_BUS, 32'h3);
        writeReg(32'h40, 16'h0, C_PC | C_INC);
        applyStimulus(S_PC, 16'h0, 10'h0);
        checkOutput("pcWePriority", O_BUS, 32'h40);
        writeReg(32'hFFFF_FFFF, 16'h0, C_PC);
        applyStimulus(S_PC, 16'h0, C_INC);
        tick();
        applyStimulus(S_PC, 16'h0, 10'h0);
        checkOutput("pcWrap", O_BUS, 32'h0);

        // Y, IR, HI, LO
        writeReg(32'h1234_5678, 16'h0, C_Y | C_IR);
        checkOutput("yOut", O_Y, 32'h1234_5678);
        checkOutput("irOut", O_IR, 32'h1234_5678);
        writeReg(32'hA5A5_A5A5, 16'h0, C_HI);
        writeReg(32'h5A5A_0001, 16'h0, C_LO);
        applyStimulus(S_HI, 16'h0, 10'h0);
        checkOutput("hi", O_BUS, 32'hA5A5_A5A5);
        applyStimulus(S_LO, 16'h0, 10'h0);
        checkOutput("lo", O_BUS, 32'h5A5A_0001);

        // Read with wait states; MDR/MAR writes during the wait are dropped
        writeReg(32'h10, 16'h0, C_MAR);
        applyStimulus(S_MDR, 16'h0, C_RD);
        tick();
        applyStimulus(S_MDR, 16'h0, 10'h0);
        checkOutput("rdReq", O_REQ, 32'h1);
        checkOutput("rdAddr", O_ADDR, 32'h10);
        writeReg(32'h5555, 16'h0, C_MDR | C_MAR);
        applyStimulus(S_MDR, 16'h0, 10'h0);
        checkOutput("rdBusy", O_BUSY, 32'h1);
        evQ.push_back('{"rdDone", 1'b0});
        memRdata = 32'h1234;
        memAck   = 1'b1;
        tick();
        memAck   = 1'b0;
        memRdata = 32'h0;
        checkOutput("rdMdr", O_BUS, 32'h1234);
        checkOutput("rdMarLocked", O_ADDR, 32'h10);
        checkOutput("rdIdle", O_BUSY, 32'h0);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        checkOutput("strayAck", O_BUS, 32'h1234);

        // Minimum latency read: ack in the first request cycle
        applyStimulus(S_MDR, 16'h0, C_RD);
        tick();
        applyStimulus(S_MDR, 16'h0, 10'h0);
        compareNow("minLatReq", {31'b0, memReq}, 32'h1);
        evQ.push_back('{"minLatDone", 1'b0});
        memRdata = 32'hCAFE;
        memAck   = 1'b1;
        tick();
        memAck   = 1'b0;
        checkOutput("minLatMdr", O_BUS, 32'hCAFE);

        // Write timeout
        evQ.push_back('{"wrTimeout", 1'b1});
        applyStimulus(S_MDR, 16'h0, C_WR);
        tick();
        applyStimulus(S_MDR, 16'h0, 10'h0);
        compareNow("wrWe", {31'b0, memWe}, 32'h1);
        errAt = 0;
        for (int k = 1; k <= TOUT + 10; k++) begin
            @(negedge clock);
            if (memErr) begin
                errAt = k;
                break;
            end
        end
        #1;
        compareNow("timeoutLatency", 32'(errAt), 32'(TOUT + 2));
        checkOutput("tmoIdle", O_BUSY, 32'h0);
        checkOutput("tmoMdr", O_BUS, 32'hCAFE);
        checkOutput("tmoWdata", O_WDATA, 32'hCAFE);
        applyStimulus(S_MDR, 16'h0, C_RD);
        tick();
        applyStimulus(S_MDR, 16'h0, 10'h0);
        tick();
        evQ.push_back('{"postTmoDone", 1'b0});
        memRdata = 32'h77;
        memAck   = 1'b1;
        tick();
        memAck   = 1'b0;
        checkOutput("postTmoMdr", O_BUS, 32'h77);

        // Z split and unused code
        loadZ(64'h0000_0001_8000_0000);
        applyStimulus(S_ZHI, 16'h0, 10'h0);
        checkOutput("zHi", O_BUS, 32'h1);
        applyStimulus(S_ZLO, 16'h0, 10'h0);
        checkOutput("zLo", O_BUS, 32'h8000_0000);
        applyStimulus(S_BAD, 16'h0, 10'h0);
        checkOutput("unusedSelB", O_BUS, 32'h0);

        // Reset in the middle of a read
        applyStimulus(S_MDR, 16'h0, C_RD);
        tick();
        applyStimulus(S_PC, 16'h0, 10'h0);
        #2;
        compareNow("preRstReq", {31'b0, memReq}, 32'h1);
        clear_n = 1'b0;
        #1;
        compareNow("rstReqDrop", {31'b0, memReq}, 32'h0);
        checkOutput("midRstPc", O_BUS, RPC);
        applyStimulus(5'd3, 16'h0, 10'h0);
        checkOutput("midRstR3", O_BUS, 32'h0);
        applyStimulus(S_MDR, 16'h0, 10'h0);
        checkOutput("midRstMdr", O_BUS, 32'h0);
        checkOutput("midRstY", O_Y, 32'h0);
        checkOutput("midRstIr", O_IR, 32'h0);
        checkOutput("midRstMar", O_ADDR, 32'h0);
        clear_n = 1'b1;
        tick(); tick();

        compareNow("probeQEmpty", 32'(probeQ.size()), 32'h0);
        compareNow("evQEmpty", 32'(evQ.size()), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
